// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encoding for the uart_brg console UART.
//   OversampleRate - receiver oversample factor (rx_tick per bit time)
//   DataBits       - payload bits per 8N1 frame
//   uart_state_e   - common encoding for the TX and RX frame state machines
package uart_pkg;

  localparam int unsigned OversampleRate = 16;
  localparam int unsigned DataBits       = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running baud-rate tick generator.
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   rx_tick - one-cycle pulse every RX_DIV clocks (16x oversample rate)
//   tx_tick - one-cycle pulse on every 16th rx_tick (bit rate)
// RX_DIV = 0 derives the divider from CLK_HZ/(BAUD*16), rounded to nearest.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned RX_DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16)
) (
  input  logic clk,
  input  logic reset,
  output logic rx_tick,
  output logic tx_tick
);

  localparam int unsigned Div     = (RX_DIV != 0) ? RX_DIV : (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned DivW    = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned OsCntW  = $clog2(OversampleRate);

  logic [DivW-1:0]   rx_cnt_q;
  logic [OsCntW-1:0] os_cnt_q;
  logic              rx_wrap;

  assign rx_wrap = (rx_cnt_q == DivW'(Div - 1));
  assign rx_tick = rx_wrap;
  assign tx_tick = rx_wrap && (os_cnt_q == OsCntW'(OversampleRate - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt_q <= '0;
      os_cnt_q <= '0;
    end else if (rx_wrap) begin
      rx_cnt_q <= '0;
      os_cnt_q <= os_cnt_q + 1'b1;
    end else begin
      rx_cnt_q <= rx_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_brg.sv
// uart_brg: 8N1 console UART with integrated baud-rate generator.
//   clk      - system clock, all state on its rising edge
//   reset    - asynchronous active-low reset
//   tx_req   - host requests transmission of tx_data (four-phase with tx_ack)
//   tx_data  - byte to send, stable while tx_req=1
//   tx_ack   - byte latched; held until tx_req drops
//   tx_empty - transmitter idle: nothing pending and stop bit finished
//   rx_req   - host requests the received byte (four-phase with rx_ack)
//   rx_ack   - byte handed over; held until rx_req drops
//   rx_data  - last valid received byte
//   rx_empty - 1 when the holding register has no unread byte
//   rx_in    - asynchronous serial input, idle high
//   tx_out   - serial output, idle high
module uart_brg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned RX_DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tx_req,
  input  logic [DataBits-1:0] tx_data,
  output logic                tx_ack,
  output logic                tx_empty,
  input  logic                rx_req,
  output logic                rx_ack,
  output logic [DataBits-1:0] rx_data,
  output logic                rx_empty,
  input  logic                rx_in,
  output logic                tx_out
);

  localparam int unsigned BitCntW = $clog2(DataBits);
  localparam int unsigned OsCntW  = $clog2(OversampleRate);

  logic rx_tick;
  logic tx_tick;

  uart_baud_gen #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .RX_DIV (RX_DIV)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .rx_tick (rx_tick),
    .tx_tick (tx_tick)
  );

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  uart_state_e         tx_state_q;
  logic [DataBits-1:0] tx_shift_q;
  logic [BitCntW-1:0]  tx_bit_cnt_q;
  logic                tx_out_q;
  logic                tx_ack_q;
  logic                tx_empty_q;

  // In StIdle, tx_empty_q=0 marks a latched byte waiting for the next bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q   <= StIdle;
      tx_shift_q   <= '0;
      tx_bit_cnt_q <= '0;
      tx_out_q     <= 1'b1;
      tx_ack_q     <= 1'b0;
      tx_empty_q   <= 1'b1;
    end else begin
      if (tx_ack_q && !tx_req) begin
        tx_ack_q <= 1'b0;
      end
      unique case (tx_state_q)
        StIdle: begin
          if (tx_empty_q) begin
            if (tx_req && !tx_ack_q) begin
              tx_shift_q <= tx_data;
              tx_ack_q   <= 1'b1;
              tx_empty_q <= 1'b0;
            end
          end else if (tx_tick) begin
            tx_state_q <= StStart;
            tx_out_q   <= 1'b0;
          end
        end
        StStart: begin
          if (tx_tick) begin
            tx_state_q   <= StData;
            tx_out_q     <= tx_shift_q[0];
            tx_shift_q   <= tx_shift_q >> 1;
            tx_bit_cnt_q <= '0;
          end
        end
        StData: begin
          if (tx_tick) begin
            if (tx_bit_cnt_q == BitCntW'(DataBits - 1)) begin
              tx_state_q <= StStop;
              tx_out_q   <= 1'b1;
            end else begin
              tx_out_q     <= tx_shift_q[0];
              tx_shift_q   <= tx_shift_q >> 1;
              tx_bit_cnt_q <= tx_bit_cnt_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (tx_tick) begin
            tx_state_q <= StIdle;
            tx_empty_q <= 1'b1;
          end
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ack   = tx_ack_q;
  assign tx_empty = tx_empty_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [1:0]          rx_sync_q;
  logic                rx_s;
  uart_state_e         rx_state_q;
  logic [OsCntW-1:0]   rx_os_cnt_q;
  logic [BitCntW-1:0]  rx_bit_cnt_q;
  logic [DataBits-1:0] rx_shift_q;
  logic [DataBits-1:0] rx_data_q;
  logic                rx_ack_q;
  logic                rx_empty_q;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync_q <= 2'b11;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_in};
    end
  end

  assign rx_s = rx_sync_q[1];

  // Host handshake is evaluated first so that a frame completing on the same
  // edge overrides rx_empty_q and leaves the new byte marked unread.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= StIdle;
      rx_os_cnt_q  <= '0;
      rx_bit_cnt_q <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_ack_q     <= 1'b0;
      rx_empty_q   <= 1'b1;
    end else begin
      if (rx_ack_q && !rx_req) begin
        rx_ack_q <= 1'b0;
      end else if (rx_req && !rx_empty_q && !rx_ack_q) begin
        rx_ack_q   <= 1'b1;
        rx_empty_q <= 1'b1;
      end
      unique case (rx_state_q)
        StIdle: begin
          if (!rx_s) begin
            rx_state_q  <= StStart;
            rx_os_cnt_q <= '0;
          end
        end
        StStart: begin
          if (rx_tick) begin
            // Half a bit in: a line that has gone high again was a glitch.
            if (rx_os_cnt_q == OsCntW'(OversampleRate / 2 - 1)) begin
              rx_os_cnt_q  <= '0;
              rx_bit_cnt_q <= '0;
              rx_state_q   <= rx_s ? StIdle : StData;
            end else begin
              rx_os_cnt_q <= rx_os_cnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (rx_tick) begin
            rx_os_cnt_q <= rx_os_cnt_q + 1'b1;
            if (rx_os_cnt_q == OsCntW'(OversampleRate - 1)) begin
              rx_shift_q <= {rx_s, rx_shift_q[DataBits-1:1]};
              if (rx_bit_cnt_q == BitCntW'(DataBits - 1)) begin
                rx_state_q <= StStop;
              end else begin
                rx_bit_cnt_q <= rx_bit_cnt_q + 1'b1;
              end
            end
          end
        end
        StStop: begin
          if (rx_tick) begin
            rx_os_cnt_q <= rx_os_cnt_q + 1'b1;
            if (rx_os_cnt_q == OsCntW'(OversampleRate - 1)) begin
              rx_state_q <= StIdle;
              // A low stop bit is a framing error: the byte is dropped silently.
              if (rx_s) begin
                rx_data_q  <= rx_shift_q;
                rx_empty_q <= 1'b0;
              end
            end
          end
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_ack   = rx_ack_q;
  assign rx_empty = rx_empty_q;

endmodule

// File: tb/tb_uart_brg.sv
module tb_uart_brg;

  localparam int unsigned RXD = 4;
  localparam int unsigned BIT = 16 * RXD;

  logic       clk;
  logic       reset;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       tx_empty;
  logic       rx_req;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       tx_out;
  logic       rx_drv;
  logic       loop;
  wire        rx_line;

  int checks;
  int errors;

  assign rx_line = loop ? tx_out : rx_drv;

  uart_brg #(
    .CLK_HZ (640_000),
    .BAUD   (10_000),
    .RX_DIV (RXD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .tx_empty (tx_empty),
    .rx_req   (rx_req),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
    .rx_in    (rx_line),
    .tx_out   (tx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_handshake(input logic [7:0] d, input string tag);
    tx_data = d;
    tx_req  = 1'b1;
    @(negedge clk);
    chk({tag, " ack rise"}, tx_ack, 1);
    chk({tag, " empty low"}, tx_empty, 0);
    tx_req = 1'b0;
    @(negedge clk);
    chk({tag, " ack fall"}, tx_ack, 0);
  endtask

  task automatic wait_tx_start(input string tag);
    for (int i = 0; i < BIT + 8; i++) begin
      @(negedge clk);
      if (tx_out === 1'b0) break;
    end
    chk({tag, " start bit"}, tx_out, 0);
  endtask

  task automatic wait_rx_full(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rx_empty === 1'b0) break;
    end
    chk({tag, " rx_empty low"}, rx_empty, 0);
  endtask

  task automatic wait_tx_idle(input string tag);
    for (int i = 0; i < 4 * BIT; i++) begin
      if (tx_empty === 1'b1) break;
      @(negedge clk);
    end
    chk({tag, " tx idle"}, tx_empty, 1);
  endtask

  // Called on the first cycle tx_out is low; samples each bit centre and
  // returns one cycle before the stop bit ends.
  task automatic capture(output logic [9:0] bits, output logic ack_seen,
                         output logic empty_seen);
    bits       = '0;
    ack_seen   = 1'b0;
    empty_seen = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < ((b == 0) ? BIT / 2 : BIT); c++) begin
        @(negedge clk);
        ack_seen   = ack_seen | tx_ack;
        empty_seen = empty_seen | tx_empty;
      end
      bits[b] = tx_out;
    end
    repeat (BIT / 2 - 1) begin
      @(negedge clk);
      ack_seen   = ack_seen | tx_ack;
      empty_seen = empty_seen | tx_empty;
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop, input int stop_len);
    rx_drv = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      cycles(BIT);
    end
    rx_drv = stop;
    cycles(stop_len);
    rx_drv = 1'b1;
  endtask

  task automatic rx_read(input string tag, input logic [7:0] exp);
    rx_req = 1'b1;
    @(negedge clk);
    chk({tag, " rx_ack rise"}, rx_ack, 1);
    chk({tag, " rx_empty set"}, rx_empty, 1);
    rx_req = 1'b0;
    @(negedge clk);
    chk({tag, " rx_ack fall"}, rx_ack, 0);
    chk({tag, " rx_data held"}, rx_data, exp);
  endtask

  initial begin : main
    logic [9:0] bits;
    logic       ack_seen;
    logic       empty_seen;
    logic [7:0] lb [3];

    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    rx_req  = 1'b0;
    rx_drv  = 1'b1;
    loop    = 1'b0;
    lb[0]   = 8'h00;
    lb[1]   = 8'hFF;
    lb[2]   = 8'hA5;

    // Reset state
    cycles(3);
    chk("rst tx_out", tx_out, 1);
    chk("rst tx_empty", tx_empty, 1);
    chk("rst rx_empty", rx_empty, 1);
    chk("rst tx_ack", tx_ack, 0);
    chk("rst rx_ack", rx_ack, 0);
    chk("rst rx_data", rx_data, 8'h00);
    reset = 1'b1;
    cycles(5);

    // TX 0x41: 0,1,0,0,0,0,0,1,0,1 (bits[0] first on the wire)
    tx_handshake(8'h41, "tx41");
    wait_tx_start("tx41");
    capture(bits, ack_seen, empty_seen);
    chk("tx41 bits", bits, 10'b10_1000_0010);
    chk("tx41 empty in frame", empty_seen, 0);
    @(negedge clk);
    chk("tx41 empty at stop end", tx_empty, 1);

    // TX back-to-back: 0x3C then 0xC3 requested mid-frame
    tx_handshake(8'h3C, "tx3c");
    wait_tx_start("tx3c");
    tx_data = 8'hC3;
    tx_req  = 1'b1;
    capture(bits, ack_seen, empty_seen);
    chk("tx3c bits", bits, 10'b10_0111_1000);
    chk("b2b no early ack", ack_seen, 0);
    @(negedge clk);
    chk("b2b empty at end", tx_empty, 1);
    chk("b2b ack not yet", tx_ack, 0);
    @(negedge clk);
    chk("b2b ack after idle", tx_ack, 1);
    tx_req = 1'b0;
    wait_tx_start("txc3");
    capture(bits, ack_seen, empty_seen);
    chk("txc3 bits", bits, 10'b11_1000_0110);
    @(negedge clk);
    chk("txc3 empty at end", tx_empty, 1);

    // RX 0x5A then host read
    rx_frame(8'h5A, 1'b1, BIT);
    cycles(2);
    chk("rx5a rx_empty", rx_empty, 0);
    chk("rx5a rx_data", rx_data, 8'h5A);
    rx_read("rx5a", 8'h5A);
    cycles(BIT);
    chk("rx5a data stable", rx_data, 8'h5A);

    // rx_req while empty is not acknowledged
    rx_req = 1'b1;
    cycles(3);
    chk("empty req no ack", rx_ack, 0);
    rx_req = 1'b0;
    cycles(1);

    // 3-tick glitch: false start
    rx_drv = 1'b0;
    cycles(3 * RXD);
    rx_drv = 1'b1;
    cycles(3 * BIT);
    chk("glitch rx_empty", rx_empty, 1);
    chk("glitch rx_data", rx_data, 8'h5A);

    // Framing error: stop bit low, byte dropped
    rx_frame(8'h33, 1'b0, 10 * RXD);
    cycles(3 * BIT);
    chk("frame err rx_empty", rx_empty, 1);
    chk("frame err rx_data", rx_data, 8'h5A);

    // Overrun: second byte overwrites
    rx_frame(8'h11, 1'b1, BIT);
    rx_frame(8'h22, 1'b1, BIT);
    cycles(BIT / 2);
    chk("overrun rx_data", rx_data, 8'h22);
    chk("overrun rx_empty", rx_empty, 0);
    rx_read("overrun", 8'h22);

    // Loopback; the last byte is left unread for the reset test
    loop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_handshake(lb[i], $sformatf("lb%0d", i));
      wait_rx_full($sformatf("lb%0d", i), 12 * BIT);
      chk($sformatf("lb%0d rx_data", i), rx_data, lb[i]);
      if (i < 2) rx_read($sformatf("lb%0d", i), lb[i]);
      wait_tx_idle($sformatf("lb%0d", i));
    end

    // Reset mid-frame aborts immediately
    tx_handshake(8'h00, "rstmid");
    wait_tx_start("rstmid");
    cycles(100);
    reset = 1'b0;
    #1;
    chk("rstmid tx_out", tx_out, 1);
    chk("rstmid tx_empty", tx_empty, 1);
    chk("rstmid rx_empty", rx_empty, 1);
    chk("rstmid tx_ack", tx_ack, 0);
    chk("rstmid rx_ack", rx_ack, 0);
    chk("rstmid rx_data", rx_data, 8'h00);
    cycles(2);
    reset = 1'b1;
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_brg.md
# uart_brg

Console serial port core: an 8N1 UART with an integrated baud-rate generator, clocked from one system clock. It sits between the console IOT controller and the physical serial pins. The IOT side exchanges bytes through two four-phase req/ack handshakes, one for transmit and one for receive.

## Interface
- CLK_HZ, 50_000_000 — system clock frequency.
- BAUD, 9600 — line rate.
- RX_DIV, CLK_HZ/(BAUD*16) rounded (326) — clocks per 16x oversample tick.
- clk  in  1  system clock. One clock; everything is on its rising edge.
- reset  in  1  reset, asynchronous and active-low (0 = reset).
- tx_req  in  1  host requests transmission of tx_data.
- tx_data  in  8  byte to send; must be stable while tx_req=1.
- tx_ack  out  1  byte latched; held until tx_req drops.
- tx_empty  out  1  transmitter idle: no byte pending and stop bit finished.
- rx_req  in  1  host requests the received byte.
- rx_ack  out  1  byte handed over; held until rx_req drops.
- rx_data  out  8  last received byte.
- rx_empty  out  1  1 = no unread byte in the holding register.
- rx_in  in  1  serial input, asynchronous, idle high.
- tx_out  out  1  serial output, idle high.

## Operation
- **Baud generator**
  - rx_tick pulses for one cycle every RX_DIV clocks.
  - tx_tick pulses on every 16th rx_tick.
  - Both counters are free-running from reset.
- **TX states:** IDLE → START → DATA(8, LSB first) → STOP → IDLE.
  - In IDLE with tx_req=1 and tx_ack=0: latch tx_data, set tx_ack=1 and tx_empty=0 on the same edge.
  - On the next tx_tick, enter START and drive tx_out=0.
  - Each following tx_tick shifts out one bit. STOP drives 1 for one bit time.
  - tx_empty returns to 1 on the tx_tick that ends the stop bit.
  - tx_ack clears the cycle after tx_req is sampled 0.
  - tx_req is ignored while tx_ack=1 or the machine is not IDLE. A new byte is accepted only after tx_ack=0 and tx_empty=1.
- **RX input:** rx_in passes through a 2-flop synchronizer.
- **RX states:** IDLE → START → DATA → STOP.
  - IDLE: a synchronized 0 enters START and counts 8 rx_ticks.
  - Input still 0 at mid-start: enter DATA. Input 1: false start, back to IDLE.
  - DATA samples every 16 rx_ticks at bit centre, 8 bits LSB first.
  - STOP samples once. Sample 1: load rx_data and clear rx_empty. Sample 0: framing error; byte discarded, rx_data and rx_empty unchanged.
  - Return to IDLE after the stop sample.
- **RX handshake:**
  - rx_req=1 with rx_empty=0 and rx_ack=0: set rx_ack=1 and rx_empty=1 on the same edge.
  - rx_data stays stable until the next valid frame completes, not just while rx_ack=1.
  - rx_ack clears the cycle after rx_req is sampled 0.
  - rx_req with rx_empty=1 is not acknowledged; rx_ack stays 0.
- **Overrun:** a new valid frame overwrites rx_data and rx_empty stays 0. There is no overrun flag.
- **Simultaneous events:** a frame completing on the same edge the host takes the byte wins. rx_data gets the new byte and rx_empty=0; the ack still completes.

## Timing
- Reset values: tx_out=1, tx_ack=0, tx_empty=1, rx_ack=0, rx_empty=1, rx_data=0x00. Counters and both FSMs are in IDLE.
- Reset asserted mid-frame aborts immediately and tx_out goes high.
- All outputs are registered.
- tx_ack rises 1 cycle after tx_req rises.
- The start bit begins ≤1 bit time after acceptance. The frame is exactly 10 tx_tick periods.
- rx_empty falls 1 cycle after the stop-sample tick. That tick is about 9.5 bit times after the start edge, plus 2 cycles of synchronizer delay.
- rx_ack rises 1 cycle after rx_req rises.

## Structure
- Sub-module uart_baud_gen holds the two tick counters; parameters CLK_HZ, BAUD, RX_DIV.
- The package uart_pkg holds the FSM state encodings (IDLE/START/DATA/STOP), the oversample constant 16 and the data width 8.
- TX and RX FSMs live in uart_brg.

## Test plan
- Reset: hold reset=0 mid-activity → tx_out=1, tx_empty=1, rx_empty=1, tx_ack=rx_ack=0, rx_data=0x00.
- TX: send 0x41 via the handshake. Required:
  - tx_ack rises 1 cycle after tx_req.
  - tx_out carries 0,1,0,0,0,0,0,1,0,1 at 16*RX_DIV clocks per bit.
  - tx_empty is 0 for the whole frame and rises at the end of the stop bit.
- TX back-to-back: second tx_req raised while tx_empty=0 → not acked until the first frame ends. Both bytes transmitted, no glitch on tx_out.
- RX: drive frame 0x5A on rx_in → rx_empty falls, rx_data=0x5A. Then rx_req → rx_ack=1 and rx_empty=1 together; rx_data still 0x5A after rx_ack drops.
- RX errors:
  - 3-tick low pulse on rx_in → no byte.
  - Frame 0x33 with stop bit 0 → discarded, rx_empty stays 1.
  - Two frames (0x11, 0x22) with no read → rx_data=0x22, rx_empty=0.
- Loopback tx_out→rx_in for bytes 0x00, 0xFF, 0xA5 → each is received intact.
